// File: rtl/sma_pkg.sv
// rtl/sma_pkg.sv - shared types and FSM states for the SMA price buffer reader
package sma_pkg;

    localparam int BUFFER_SIZE_DEF = 64;
    localparam int NUM_STOCKS_DEF  = 4;
    localparam int PRICE_WIDTH_DEF = 32;
    localparam int LOG2_BUF        = $clog2(BUFFER_SIZE_DEF);

    typedef logic [$clog2(NUM_STOCKS_DEF)-1:0]                  stock_id_t;
    typedef logic [PRICE_WIDTH_DEF-1:0]                         price_t;
    typedef logic [PRICE_WIDTH_DEF+LOG2_BUF-1:0]                sum_t;
    typedef logic [$clog2(BUFFER_SIZE_DEF*NUM_STOCKS_DEF)-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        UPDATE
    } sma_rd_state_e;

endpackage

// File: rtl/sma_sum_bank.sv
// rtl/sma_sum_bank.sv - per-stock running sum and saturating fill count, 1 read / 1 write port
module sma_sum_bank #(
    parameter int NUM_STOCKS = 4,
    parameter int SID_W      = 2,
    parameter int SUM_W      = 38,
    parameter int CNT_W      = 7
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [SID_W-1:0] rd_sid,
    output logic [SUM_W-1:0] rd_sum,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic [SID_W-1:0] wr_sid,
    input  logic [SUM_W-1:0] wr_sum,
    input  logic [CNT_W-1:0] wr_cnt
);

    logic [SUM_W-1:0] sum_r [NUM_STOCKS];
    logic [CNT_W-1:0] cnt_r [NUM_STOCKS];

    assign rd_sum = sum_r[rd_sid];
    assign rd_cnt = cnt_r[rd_sid];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                sum_r[i] <= '0;
                cnt_r[i] <= '0;
            end
        end else if (wr_en) begin
            sum_r[wr_sid] <= wr_sum;
            cnt_r[wr_sid] <= wr_cnt;
        end
    end

endmodule

// File: rtl/sma_price_buffer_reader.sv
// rtl/sma_price_buffer_reader.sv - reads evicted slot, maintains per-stock sums, emits SMA (SMA_ROUND_EN: rounded, saturating mean)
module sma_price_buffer_reader
    import sma_pkg::*;
#(
    parameter int BUFFER_SIZE = 64,
    parameter int NUM_STOCKS  = 4,
    parameter int PRICE_WIDTH = 32,
    parameter int RD_LATENCY  = 1,
    localparam int ADDR_WIDTH = $clog2(BUFFER_SIZE*NUM_STOCKS),
    localparam int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int SHIFT      = $clog2(BUFFER_SIZE),
    localparam int SUM_W      = PRICE_WIDTH + SHIFT
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_upd_valid,
    output logic                   o_upd_ready,
    input  logic [SID_W-1:0]       i_upd_stock_id,
    input  logic [PRICE_WIDTH-1:0] i_upd_price,
    input  logic [ADDR_WIDTH-1:0]  i_upd_addr,
    output logic                   o_mem_busy,
    output logic                   o_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_rd_addr,
    input  logic [PRICE_WIDTH-1:0] i_rd_data,
    output logic                   o_sma_valid,
    output logic [SID_W-1:0]       o_sma_stock_id,
    output logic [PRICE_WIDTH-1:0] o_sma_price,
    output logic                   o_sma_primed
);

    localparam int CNT_W  = $clog2(BUFFER_SIZE + 1);
    localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    sma_rd_state_e          state;
    logic [SID_W-1:0]       sid_q;
    logic [PRICE_WIDTH-1:0] price_q;
    logic [PRICE_WIDTH-1:0] old_q;
    logic                   full_q;
    logic [WCNT_W-1:0]      wait_cnt;

    logic                   pend_valid;
    logic [SID_W-1:0]       pend_sid;
    logic [PRICE_WIDTH-1:0] pend_price;
    logic                   pend_primed;

    logic [SID_W-1:0]       bank_rd_sid;
    logic [SUM_W-1:0]       bank_sum;
    logic [CNT_W-1:0]       bank_cnt;
    logic [SUM_W-1:0]       new_sum;
    logic [CNT_W-1:0]       new_cnt;
    logic [PRICE_WIDTH-1:0] sma_calc;

    // In IDLE the bank is addressed by the incoming stock so the fill check is ready at accept.
    assign bank_rd_sid = (state == IDLE) ? i_upd_stock_id : sid_q;

    sma_sum_bank #(
        .NUM_STOCKS (NUM_STOCKS),
        .SID_W      (SID_W),
        .SUM_W      (SUM_W),
        .CNT_W      (CNT_W)
    ) u_sum_bank (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .rd_sid    (bank_rd_sid),
        .rd_sum    (bank_sum),
        .rd_cnt    (bank_cnt),
        .wr_en     (state == UPDATE),
        .wr_sid    (sid_q),
        .wr_sum    (new_sum),
        .wr_cnt    (new_cnt)
    );

    // old_q is zero for a not-yet-full stock, so one expression covers both paths.
    assign new_sum = bank_sum - SUM_W'(old_q) + SUM_W'(price_q);
    assign new_cnt = full_q ? bank_cnt : bank_cnt + CNT_W'(1);

`ifdef SMA_ROUND_EN
    logic [PRICE_WIDTH:0] rounded;
    assign rounded  = (PRICE_WIDTH+1)'(({1'b0, new_sum} + (SUM_W+1)'(BUFFER_SIZE/2)) >> SHIFT);
    assign sma_calc = rounded[PRICE_WIDTH] ? {PRICE_WIDTH{1'b1}} : rounded[PRICE_WIDTH-1:0];
`else
    assign sma_calc = new_sum[SHIFT +: PRICE_WIDTH];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            sid_q          <= '0;
            price_q        <= '0;
            old_q          <= '0;
            full_q         <= 1'b0;
            wait_cnt       <= '0;
            pend_valid     <= 1'b0;
            pend_sid       <= '0;
            pend_price     <= '0;
            pend_primed    <= 1'b0;
            o_upd_ready    <= 1'b1;
            o_mem_busy     <= 1'b0;
            o_rd_en        <= 1'b0;
            o_rd_addr      <= '0;
            o_sma_valid    <= 1'b0;
            o_sma_stock_id <= '0;
            o_sma_price    <= '0;
            o_sma_primed   <= 1'b0;
        end else begin
            o_rd_en     <= 1'b0;
            pend_valid  <= 1'b0;
            o_sma_valid <= pend_valid;
            if (pend_valid) begin
                o_sma_stock_id <= pend_sid;
                o_sma_price    <= pend_price;
                o_sma_primed   <= pend_primed;
            end

            case (state)
                IDLE: begin
                    if (i_upd_valid) begin
                        sid_q       <= i_upd_stock_id;
                        price_q     <= i_upd_price;
                        old_q       <= '0;
                        o_upd_ready <= 1'b0;
                        if (bank_cnt == CNT_W'(BUFFER_SIZE)) begin
                            full_q     <= 1'b1;
                            o_mem_busy <= 1'b1;
                            o_rd_en    <= 1'b1;
                            o_rd_addr  <= i_upd_addr;
                            state      <= READ;
                        end else begin
                            full_q <= 1'b0;
                            state  <= UPDATE;
                        end
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WCNT_W'(RD_LATENCY - 1)) begin
                        old_q      <= i_rd_data;
                        o_mem_busy <= 1'b0;
                        state      <= UPDATE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                UPDATE: begin
                    pend_valid  <= 1'b1;
                    pend_sid    <= sid_q;
                    pend_price  <= sma_calc;
                    pend_primed <= (new_cnt == CNT_W'(BUFFER_SIZE));
                    o_upd_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
